sram_access_arbiter: RTL

Shares the single SRAM_Controller port between three requesters: 0 = colorspace (milestone 1) engine, 1 = IDCT (milestone 2) fetch/write-back engine, 2 = VGA/debug reader.

The block drives the SRAM_Controller's SRAM_address, SRAM_write_data and SRAM_we_n inputs and returns tagged read-valid strobes. Arbitration is round-robin with burst locking, so a requester streaming sequential Y/U/V/RGB accesses keeps the bus until it releases it or hits the burst cap.

---
 rtl/sram_access_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares one SRAM_Controller port
// between three requesters, round-robin with burst lock.
module sram_access_arbiter #(
  parameter int MAX_BURST    = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        sram_ready_i,
  input  logic [2:0]  req_i,
  input  logic [2:0]  we_n_i,
  input  logic [53:0] addr_i,
  input  logic [47:0] wdata_i,
  output logic [2:0]  gnt_o,
  output logic [2:0]  rvalid_o,
  output logic [15:0] rdata_o,
  input  logic [15:0] sram_read_data_i,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  localparam int         DEPTH = READ_LATENCY + 1;
  localparam logic [3:0] CAP   = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN,
    ARB_GAP
  } arb_t;

  arb_t        r_state;
  logic [1:0]  r_owner;
  logic [1:0]  r_rr_ptr;
  logic [3:0]  r_burst_cnt;

  logic [1:0]  w_p0;
  logic [1:0]  w_p1;
  logic [1:0]  w_p2;
  logic [1:0]  w_win;
  logic        w_win_vld;
  logic [2:0]  w_owner_oh;
  logic        w_others;
  logic        w_cap;
  logic        w_own_ok;
  logic        w_gnt_vld;
  logic [1:0]  w_gnt_id;
  logic [2:0]  w_gnt;
  logic [17:0] w_addr;
  logic [15:0] w_wdata;
  logic        w_we_n;

  logic        r_pv  [DEPTH];
  logic [1:0]  r_pid [DEPTH];

  function automatic logic [1:0] inc3(
    input logic [1:0] p
  );
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_p0 = r_rr_ptr;
  assign w_p1 = inc3(w_p0);
  assign w_p2 = inc3(w_p1);

  // first requester at or after the round-robin pointer
  always_comb begin
    w_win     = w_p0;
    w_win_vld = 1'b1;
    if (req_i[w_p0])
      w_win = w_p0;
    else if (req_i[w_p1])
      w_win = w_p1;
    else if (req_i[w_p2])
      w_win = w_p2;
    else
      w_win_vld = 1'b0;
  end

  assign w_owner_oh = 3'b001 << r_owner;
  assign w_others   = |(req_i & ~w_owner_oh);
  assign w_cap      = (r_burst_cnt == CAP) && w_others;
  assign w_own_ok   = req_i[r_owner] && sram_ready_i
                      && !w_cap;

  // grant decision for the current cycle
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = r_owner;
    unique case (r_state)
      ARB_IDLE: begin
        w_gnt_vld = sram_ready_i & w_win_vld;
        w_gnt_id  = w_win;
      end
      ARB_OWN: begin
        w_gnt_vld = w_own_ok;
      end
      default: begin
        w_gnt_vld = 1'b0;
      end
    endcase
  end

  assign w_gnt = w_gnt_vld ? (3'b001 << w_gnt_id) : 3'b000;
  assign gnt_o = w_gnt & {3{resetn}};

  // select the granted requester's access fields
  always_comb begin
    w_addr  = addr_i[17:0];
    w_wdata = wdata_i[15:0];
    w_we_n  = we_n_i[0];
    case (w_gnt_id)
      2'd1: begin
        w_addr  = addr_i[35:18];
        w_wdata = wdata_i[31:16];
        w_we_n  = we_n_i[1];
      end
      2'd2: begin
        w_addr  = addr_i[53:36];
        w_wdata = wdata_i[47:32];
        w_we_n  = we_n_i[2];
      end
      default: begin
        w_addr  = addr_i[17:0];
        w_wdata = wdata_i[15:0];
        w_we_n  = we_n_i[0];
      end
    endcase
  end

  // tenure FSM; burst count saturates at the cap
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ARB_IDLE;
      r_owner     <= 2'd0;
      r_rr_ptr    <= 2'd0;
      r_burst_cnt <= 4'd0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_gnt_vld) begin
            r_owner     <= w_win;
            r_burst_cnt <= 4'd1;
            r_state     <= ARB_OWN;
          end
        end
        ARB_OWN: begin
          if (w_own_ok) begin
            if (r_burst_cnt != CAP)
              r_burst_cnt <= r_burst_cnt + 4'd1;
          end else begin
            r_rr_ptr <= inc3(r_owner);
            r_state  <= ARB_GAP;
          end
        end
        ARB_GAP: begin
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // register the granted access toward the controller
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      SRAM_we_n       <= 1'b1;
    end else if (w_gnt_vld) begin
      SRAM_address    <= w_addr;
      SRAM_write_data <= w_wdata;
      SRAM_we_n       <= w_we_n;
    end else begin
      SRAM_we_n       <= 1'b1;
    end
  end

  // tag pipe aligning read grants with returning data
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pv[i]  <= 1'b0;
        r_pid[i] <= 2'd0;
      end
    end else begin
      r_pv[0]  <= w_gnt_vld & w_we_n;
      r_pid[0] <= w_gnt_id;
      for (int i = 1; i < DEPTH; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pid[i] <= r_pid[i-1];
      end
    end
  end

  assign rvalid_o = r_pv[DEPTH-1]
                    ? (3'b001 << r_pid[DEPTH-1])
                    : 3'b000;
  assign rdata_o  = sram_read_data_i;

endmodule
